// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg
// Shared helpers for adder_tree:
//   tree_stages  - number of pairwise-add levels for a given input count
//   range_hi/lo  - representable range of a BITS-wide result (signed or unsigned)
//   resize_sum   - range check plus saturate/wrap of a full-precision sum
package adder_tree_pkg;

  typedef struct packed {
    logic        ovf;
    logic [31:0] val;
  } resize_t;

  function automatic int tree_stages(int num);
    return (num <= 2) ? 1 : $clog2(num);
  endfunction

  function automatic logic signed [63:0] range_hi(int bits, bit sgn);
    if (sgn) return (64'sd1 <<< (bits - 1)) - 64'sd1;
    return (64'sd1 <<< bits) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] range_lo(int bits, bit sgn);
    if (sgn) return -(64'sd1 <<< (bits - 1));
    return 64'sd0;
  endfunction

  // s arrives already sign- or zero-extended to 64 bits, so one signed
  // compare covers both operand modes.
  function automatic resize_t resize_sum(logic signed [63:0] s, int bits,
                                         bit sgn, bit sat);
    resize_t            r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] pick;
    logic signed [63:0] mask;
    hi    = range_hi(bits, sgn);
    lo    = range_lo(bits, sgn);
    r.ovf = (s > hi) || (s < lo);
    pick  = s;
    if (r.ovf && sat) pick = (s > hi) ? hi : lo;
    mask  = (64'sd1 <<< bits) - 64'sd1;
    r.val = 32'(pick & mask);
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// adder_tree_level
// One level of the registered adder tree: M operands of width W are summed
// in adjacent pairs into M/2 results of width W+1 (no loss of precision).
// Ports:
//   clk, reset          - clock, synchronous active-high reset (valid only)
//   in_valid, in_data   - operands from the previous level
//   next_load           - the following stage takes our result this cycle
//   load                - this stage captures new data this cycle
//   out_valid, out_data - registered pairwise sums
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int W   = 16,
  parameter int M   = 4,
  parameter int SGN = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [M-1:0][W-1:0]    in_data,
  input  logic                   next_load,
  output logic                   load,
  output logic                   out_valid,
  output logic [M/2-1:0][W:0]    out_data
);

  logic [M-1:0][W:0] ext_data;

  always_comb begin
    ext_data = '0;
    for (int i = 0; i < M; i++)
      ext_data[i] = {((SGN != 0) ? in_data[i][W-1] : 1'b0), in_data[i]};
  end

  // An empty stage always loads, so bubbles are squeezed out under stall.
  assign load = !out_valid || next_load;

  always_ff @(posedge clk) begin
    if (reset) out_valid <= 1'b0;
    else if (load) out_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < M/2; j++)
        out_data[j] <= ext_data[2*j] + ext_data[2*j+1];
    end
  end

endmodule

// File: rtl/adder_tree.sv
// adder_tree
// Pipelined NUM-input adder: a registered binary tree of adder_tree_level
// instances followed by a registered resize stage (saturate or wrap), with
// a valid/ready handshake on both sides and overflow status.
// Optional feature: define ADDER_TREE_OVF_CNT_EN to add ovf_cnt, a 16-bit
// saturating count of delivered overflowed results.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   valid, ready, data_in    - input beat handshake and packed operands
//   o, o_overflow            - result and its out-of-range flag
//   valid_out, ready_out     - output handshake
//   overflow_sticky, clear   - sticky overflow status and its clear
//   ovf_cnt                  - overflow count (ADDER_TREE_OVF_CNT_EN only)
module adder_tree
  import adder_tree_pkg::*;
#(
  parameter int BITS   = 16,
  parameter int NUM    = 4,
  parameter int SIGNED = 1,
  parameter int SAT    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid,
  output logic                      ready,
  input  logic [NUM-1:0][BITS-1:0]  data_in,
  output logic [BITS-1:0]           o,
  output logic                      o_overflow,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic                      overflow_sticky,
`ifdef ADDER_TREE_OVF_CNT_EN
  output logic [15:0]               ovf_cnt,
`endif
  input  logic                      clear
);

  localparam int STAGES = tree_stages(NUM);
  localparam int NP     = 1 << STAGES;
  localparam int SW     = BITS + STAGES;

  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_load;
  logic [STAGES-1:0] stg_next;
  logic              out_load;
  logic              xfer_out;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_lvl
    localparam int W = BITS + k;
    localparam int M = NP >> k;
    logic [M-1:0][W-1:0]   din;
    logic [M/2-1:0][W:0]   dout;
    logic                  vin;

    if (k == 0) begin : g_src
      // Missing operands up to the next power of two are zero.
      always_comb begin
        din = '0;
        for (int i = 0; i < NUM; i++) din[i] = data_in[i];
      end
      assign vin = valid;
    end else begin : g_src
      assign din = g_lvl[k-1].dout;
      assign vin = stg_valid[k-1];
    end

    if (k == STAGES - 1) begin : g_nxt
      assign stg_next[k] = out_load;
    end else begin : g_nxt
      assign stg_next[k] = stg_load[k+1];
    end

    adder_tree_level #(.W(W), .M(M), .SGN(SIGNED)) u_level (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (vin),
      .in_data   (din),
      .next_load (stg_next[k]),
      .load      (stg_load[k]),
      .out_valid (stg_valid[k]),
      .out_data  (dout)
    );
  end

  logic [SW-1:0]      sum_top;
  logic signed [63:0] s_full;
  resize_t            res;
  logic               unused_val;

  assign sum_top = g_lvl[STAGES-1].dout[0];

  always_comb begin
    if (SIGNED != 0) s_full = {{(64-SW){sum_top[SW-1]}}, sum_top};
    else             s_full = {{(64-SW){1'b0}}, sum_top};
  end

  assign res        = resize_sum(s_full, BITS, SIGNED != 0, SAT != 0);
  assign unused_val = ^res.val;

  assign out_load = !valid_out || ready_out;
  assign xfer_out = valid_out && ready_out;
  assign ready    = stg_load[0] && !reset;

  always_ff @(posedge clk) begin
    if (reset) valid_out <= 1'b0;
    else if (out_load) valid_out <= stg_valid[STAGES-1];
  end

  // Result registers only move on a real beat, so idle cycles keep the
  // last delivered value instead of absorbing undriven tree contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      o          <= '0;
      o_overflow <= 1'b0;
    end else if (out_load && stg_valid[STAGES-1]) begin
      o          <= res.val[BITS-1:0];
      o_overflow <= res.ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) overflow_sticky <= 1'b0;
    else if (xfer_out && o_overflow) overflow_sticky <= 1'b1;
  end

`ifdef ADDER_TREE_OVF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || clear) ovf_cnt <= '0;
    else if (xfer_out && o_overflow && (ovf_cnt != 16'hFFFF)) ovf_cnt <= ovf_cnt + 16'd1;
  end
`endif

endmodule
